sync_fifo_drain: RTL and testbench

//  Read-side controller for sync_fifo. Pops words whenever the FIFO is non-empty and downstream
//  has room, then presents them on a valid/ready stream port (m_*). A 2-entry skid buffer

---
 rtl/sync_fifo_drain_pkg.sv | 13 +
 rtl/sync_fifo_drain_if.sv | 32 +++
 rtl/sync_fifo_drain_skid_buf2.sv | 74 +++++++
 rtl/sync_fifo_drain.sv | 63 ++++++
 tb/tb_sync_fifo_drain.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_drain_pkg.sv
// Shared constants for the sync_fifo read-side drain: default data width and
// skid-buffer occupancy encoding.
package sync_fifo_drain_pkg;

    localparam int FIFO_DWIDTH = 32;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/sync_fifo_drain_if.sv
// FIFO read port plus valid/ready stream port seen by the drain controller.
// master = drain side, slave = FIFO/consumer side.
interface sync_fifo_drain_if #(
    parameter int DWIDTH = sync_fifo_drain_pkg::FIFO_DWIDTH
) ();

    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dataout;
    logic              fifo_rn;
    logic [DWIDTH-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dataout,
        output fifo_rn,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_dataout,
        input  fifo_rn,
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/sync_fifo_drain_skid_buf2.sv
// 2-entry valid/ready skid buffer; push lands next edge, head is registered.
// Caller must never push while full without popping in the same cycle.
module sync_fifo_drain_skid_buf2
    import sync_fifo_drain_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] push_data_i,
    input  logic              pop_i,
    output occ_t              occ_o,
    output logic [DWIDTH-1:0] head_data_o,
    output logic              head_valid_o
);

    logic [DWIDTH-1:0] ent0_q, ent0_d;
    logic [DWIDTH-1:0] ent1_q, ent1_d;
    occ_t              occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    ent0_d = push_data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push_i && pop_i) begin
                    ent0_d = push_data_i;
                end else if (pop_i) begin
                    occ_d = OCC_EMPTY;
                end else if (push_i) begin
                    ent1_d = push_data_i;
                    occ_d  = OCC_FULL;
                end
            end
            OCC_FULL: begin
                // Skid slot moves to the head whenever the head leaves.
                if (pop_i) begin
                    ent0_d = ent1_q;
                    if (push_i) begin
                        ent1_d = push_data_i;
                    end else begin
                        occ_d = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o        = occ_q;
    assign head_data_o  = ent0_q;
    assign head_valid_o = (occ_q != OCC_EMPTY);

endmodule

// File: rtl/sync_fifo_drain.sv
// Drains sync_fifo onto a valid/ready stream; first word 2 cycles after empty falls, 1 word/clk.
// Reads are credit-limited to skid space, so m_ready=0 stalls with at most 2 words held.
module sync_fifo_drain
    import sync_fifo_drain_pkg::*;
#(
    parameter int DWIDTH = FIFO_DWIDTH,
    parameter int CWIDTH = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    sync_fifo_drain_if.master   bus,
    output logic                busy,
    output logic [CWIDTH-1:0]   word_count
);

    logic              inflight_q;
    logic [CWIDTH-1:0] word_count_q, word_count_d;
    logic              pop;
    logic              rn;
    logic [2:0]        committed;
    occ_t              occ;
    logic [DWIDTH-1:0] head_data;
    logic              head_valid;

    assign pop = head_valid && bus.m_ready;

    // pop implies occ >= 1, so this never underflows.
    assign committed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign rn        = enable && !bus.fifo_empty && !reset && (committed < 3'd2);

    assign word_count_d = pop ? word_count_q + CWIDTH'(1) : word_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            inflight_q   <= rn;
            word_count_q <= word_count_d;
        end
    end

    sync_fifo_drain_skid_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clock        (clock),
        .reset        (reset),
        .push_i       (inflight_q),
        .push_data_i  (bus.fifo_dataout),
        .pop_i        (pop),
        .occ_o        (occ),
        .head_data_o  (head_data),
        .head_valid_o (head_valid)
    );

    assign bus.fifo_rn = rn;
    assign bus.m_data  = head_data;
    assign bus.m_valid = head_valid;
    assign busy        = (occ != OCC_EMPTY) || inflight_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_sync_fifo_drain.sv
// Directed bench for sync_fifo_drain with a behavioural sync_fifo model and a
// second narrow-counter instance for the word_count wrap.
module tb_sync_fifo_drain;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        enable2 = 1'b0;
    logic        busy, busy2;
    logic [15:0] word_count;
    logic [2:0]  word_count2;

    int checks = 0;
    int errors = 0;

    sync_fifo_drain_if #(.DWIDTH(32)) bus  ();
    sync_fifo_drain_if #(.DWIDTH(32)) bus2 ();

    sync_fifo_drain #(.DWIDTH(32), .CWIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .word_count (word_count)
    );

    sync_fifo_drain #(.DWIDTH(32), .CWIDTH(3)) dut_wrap (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable2),
        .bus        (bus2),
        .busy       (busy2),
        .word_count (word_count2)
    );

    always #5 clock = ~clock;

    // sync_fifo model: dataout registered one cycle after rn.
    logic [31:0] fmem [64];
    int          wr_ptr   = 0;
    int          rd_ptr   = 0;
    logic        fifo_clr = 1'b0;
    logic [31:0] fifo_q   = '0;

    assign bus.fifo_empty   = (rd_ptr == wr_ptr);
    assign bus.fifo_dataout = fifo_q;

    always @(posedge clock) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rn) begin
            fifo_q <= fmem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Never-empty source for the wrap instance.
    logic [31:0] src2 = '0;
    assign bus2.fifo_empty   = 1'b0;
    assign bus2.fifo_dataout = src2;
    always @(posedge clock) if (bus2.fifo_rn) src2 <= src2 + 1;

    logic [31:0] got  [$];
    int          gcyc [$];
    int          cyc    = 0;
    int          rn_cnt = 0;
    int          cnt2   = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.fifo_rn) rn_cnt <= rn_cnt + 1;
        if (!reset && bus.m_valid && bus.m_ready) begin
            got.push_back(bus.m_data);
            gcyc.push_back(cyc);
        end
        if (!reset && bus2.m_valid && bus2.m_ready) cnt2 <= cnt2 + 1;
    end

    logic [31:0] exp_w [7] = '{32'd10, 32'd15, 32'd20, 32'd30, 32'd35, 32'd40, 32'd45};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load7();
        for (int i = 0; i < 7; i++) fmem[(wr_ptr + i) % 64] = exp_w[i];
        wr_ptr = wr_ptr + 7;
    endtask

    task automatic wait_words(input int base, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got.size() - base >= n) break;
            tick();
        end
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_count"}, got.size() - base, 7);
        for (int i = 0; i < 7; i++) begin
            if (base + i < got.size())
                check($sformatf("%s_w%0d", tag, i), got[base + i], exp_w[i]);
        end
    endtask

    initial begin
        int base;
        int rn0;
        bus.m_ready  = 1'b1;
        bus2.m_ready = 1'b1;
        enable       = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_word_count", word_count, 0);
        check("rst_busy", busy, 0);
        load7();
        #1;
        check("rst_rn_blocked", bus.fifo_rn, 0);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        reset    = 1'b0;
        tick();

        // 1: streaming, ready held high
        load7();
        #1;
        check("t1_rn_first", bus.fifo_rn, 1);
        tick();
        check("t1_valid_lat1", bus.m_valid, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t1_valid_%0d", i), bus.m_valid, 1);
            check($sformatf("t1_data_%0d", i), bus.m_data, exp_w[i]);
        end
        tick();
        check("t1_valid_end", bus.m_valid, 0);
        check("t1_word_count", word_count, 7);
        check("t1_busy", busy, 0);

        // 2: back-pressure for 10 cycles
        bus.m_ready = 1'b0;
        rn0 = rn_cnt;
        load7();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) check("t2_hold_early", bus.m_data, 10);
        end
        check("t2_rn_pulses", rn_cnt - rn0, 2);
        check("t2_fifo_left", wr_ptr - rd_ptr, 5);
        check("t2_valid_held", bus.m_valid, 1);
        check("t2_data_held", bus.m_data, 10);
        check("t2_busy", busy, 1);
        base = got.size();
        bus.m_ready = 1'b1;
        wait_words(base, 7, 30);
        check_stream("t2", base);
        if (got.size() - base >= 7) check("t2_no_gaps", gcyc[base + 6] - gcyc[base], 6);
        tick();
        tick();
        check("t2_word_count", word_count, 14);

        // 3: ready toggling
        base = got.size();
        load7();
        for (int i = 0; i < 60; i++) begin
            if (got.size() - base >= 7) break;
            tick();
            bus.m_ready = ~bus.m_ready;
        end
        bus.m_ready = 1'b1;
        repeat (4) tick();
        check_stream("t3", base);
        check("t3_word_count", word_count, 21);
        check("t3_busy", busy, 0);

        // 4: drain disabled
        enable = 1'b0;
        rn0 = rn_cnt;
        load7();
        repeat (5) tick();
        check("t4_rn_none", rn_cnt - rn0, 0);
        check("t4_rn_now", bus.fifo_rn, 0);
        check("t4_valid", bus.m_valid, 0);
        check("t4_busy", busy, 0);
        base = got.size();
        enable = 1'b1;
        wait_words(base, 7, 30);
        tick();
        check_stream("t4", base);
        check("t4_word_count", word_count, 28);

        // 5: async reset mid-stream
        base = got.size();
        load7();
        wait_words(base, 3, 20);
        check("t5_before_inflight", busy, 1);
        reset = 1'b1;
        #1;
        check("t5_valid", bus.m_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_word_count", word_count, 0);
        check("t5_rn", bus.fifo_rn, 0);
        tick();
        check("t5_rn_hold", bus.fifo_rn, 0);
        check("t5_no_more", got.size() - base, 3);
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        reset    = 1'b0;
        tick();

        // 6: narrow counter wrap
        enable2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cnt2 == 7) check("t6_wc7", word_count2, 7);
            if (cnt2 == 8) check("t6_wc0", word_count2, 0);
            if (cnt2 == 9) begin
                check("t6_wc1", word_count2, 1);
                enable2 = 1'b0;
                break;
            end
        end
        check("t6_reached9", cnt2 >= 9, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
